complex_div: RTL and testbench
==============================

# complex_div

Iterative complex divider: computes q = num / den for 16-bit signed complex operands and returns a fixed-point complex quotient with FRAC fractional bits. It is the inverse of the datapath's complex twiddle multiply. It sits after an FFT stage for equalisation and normalisation, and is used to undo a known complex gain. It is one shared unit behind a valid/ready handshake, multi-cycle, with one operation in flight at a time.

## Interface
- FRAC, 8: fractional bits of the quotient outputs (0..15).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set is valid.
- in_ready  out  1  unit is idle and accepts operands.
- num_r, num_i  in  16  numerator real/imag, signed two's complement integers.
- den_r, den_i  in  16  denominator real/imag, signed.
- out_valid  out  1  result is valid and held until accepted.
- out_ready  in  1  consumer accepts the result.
- q_r, q_i  out  16  quotient real/imag, signed, FRAC fractional bits.
- sat  out  1  at least one quotient component was saturated.
- div_zero  out  1  the denominator was 0+0i.

## Operation
- States: IDLE, MUL, DIV, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE: on in_valid, register the operands and go to MUL.
- MUL, one cycle:
  - n_r = num_r·den_r + num_i·den_i and n_i = num_i·den_r − num_r·den_i, both 33-bit signed.
  - m = den_r² + den_i², 32-bit unsigned.
  - Latch the signs of n_r and n_i, and their 32-bit magnitudes. The maximum magnitude is 2^31.
  - If m == 0: q_r = q_i = 0x7FFF, div_zero = 1, sat = 0, go to DONE.
  - Otherwise go to DIV.
- DIV: two restoring dividers share the divisor m.
  - Each dividend is |n| << FRAC, (32+FRAC) bits wide.
  - One quotient bit per cycle, MSB first; 32+FRAC cycles, counted by an iteration counter.
  - The result is truncated toward zero (magnitude truncation).
- DIV exit, on the final iteration edge, per component:
  - Magnitude qm; a sign-negative result is negated.
  - Saturate to 16-bit: positive with qm > 32767 gives 0x7FFF; negative with qm > 32768 gives 0x8000.
  - sat = OR of both component saturations. Go to DONE.
- DONE: hold q_r, q_i, sat and div_zero stable. On out_ready, go to IDLE. Outputs keep their values in IDLE until the next result.
- Operand inputs are ignored while the unit is not in IDLE. in_valid held with in_ready low causes no action.
- in_ready is low in DONE, so there is no accept in the same cycle as a result handoff. Back-to-back throughput is one result per L+2 cycles.

## Timing
- Reset (rst_n low, asynchronous, any state including mid-DIV):
  - State returns to IDLE and the in-flight operation is discarded.
  - q_r = q_i = 0, sat = 0, div_zero = 0, out_valid = 0, in_ready = 1 after reset.
- Acceptance edge is the rising edge with in_valid & in_ready.
- Latency L, from the acceptance edge to the edge that raises out_valid:
  - Normal: L = 1 + 32 + FRAC, which is 41 for FRAC = 8.
  - Divide by zero: L = 1.
  - With rounding enabled, add 1 to the normal latency.
- out_valid is registered. No output depends combinationally on any input.
- A result is held for any number of cycles with out_ready low.

## Configuration
- COMPLEX_DIV_ROUND_EN defined:
  - DIV runs one extra iteration (33+FRAC) to produce a guard bit.
  - The magnitude is rounded half-up (qm = (qm2 + 1) >> 1) before sign restore and saturation, which gives round half away from zero.
  - Latency is 42 for FRAC = 8.
- Undefined: pure truncation toward zero, as in Operation.

## Test plan
- Basic divide, FRAC = 8: num = (3,4), den = (1,2) -> q_r = 0x0233 (563), q_i = 0xFF9A (−102), sat = 0, out_valid exactly 41 edges after acceptance.
- Rounding: num = (2,0), den = (3,0) -> q_r = 170 without the macro, 171 with COMPLEX_DIV_ROUND_EN; q_i = 0 in both cases.
- Saturation: num = (32767,0), den = (1,0) -> q_r = 0x7FFF, sat = 1. num = (−32768,0), den = (1,0) -> q_r = 0x8000, sat = 1.
- Divide by zero: den = (0,0), num = (5,5) -> q_r = q_i = 0x7FFF, div_zero = 1, out_valid 1 edge after acceptance.
- Handshake:
  - Hold out_ready low 10 cycles after the result: outputs stay stable and in_ready stays 0.
  - A new in_valid during DIV is ignored.
  - After out_ready, the next operand set is accepted and produces the correct result.
- Reset mid-operation: assert rst_n low during cycle 20 of DIV -> immediate IDLE with all outputs 0. A subsequent operation produces the correct result with full latency.

Source files
------------

// File: rtl/complex_div_if.sv
// complex_div_if: operand/result handshake bundle for the iterative complex divider
interface complex_div_if;
  logic in_valid;
  logic in_ready;
  logic signed [15:0] num_r;
  logic signed [15:0] num_i;
  logic signed [15:0] den_r;
  logic signed [15:0] den_i;
  logic out_valid;
  logic out_ready;
  logic [15:0] q_r;
  logic [15:0] q_i;
  logic sat;
  logic div_zero;
  modport master (
    output in_valid, num_r, num_i, den_r, den_i, out_ready,
    input  in_ready, out_valid, q_r, q_i, sat, div_zero
  );
  modport slave (
    input  in_valid, num_r, num_i, den_r, den_i, out_ready,
    output in_ready, out_valid, q_r, q_i, sat, div_zero
  );
endinterface

// File: rtl/complex_div.sv
// complex_div: iterative q = num/den, FRAC-bit fixed-point complex quotient via two restoring dividers
// Optional COMPLEX_DIV_ROUND_EN adds a guard iteration and rounds the magnitude half-up.
module complex_div #(
  parameter int FRAC = 8
) (
  input logic clk,
  input logic rst_n,
  complex_div_if.slave bus
);
`ifdef COMPLEX_DIV_ROUND_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int W = 32 + FRAC + G;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;
  logic signed [15:0] a_r, a_i, b_r, b_i;
  logic signed [31:0] p_rr, p_ii, p_ir, p_ri, p_br, p_bi;
  logic signed [32:0] n_r, n_i;
  logic [31:0] mag_r, mag_i, m_w, m;
  logic [31:0] rem_r, rem_i, rn_r, rn_i;
  logic [W-1:0] quo_r, quo_i, qn_r, qn_i;
  logic [W:0] qm_r, qm_i;
  logic [16:0] s_r, s_i;
  logic neg_r, neg_i, last;
  logic [5:0] cnt;
  logic [15:0] q_r, q_i;
  logic sat, div_zero;
  assign p_rr = 32'(a_r) * 32'(b_r);
  assign p_ii = 32'(a_i) * 32'(b_i);
  assign p_ir = 32'(a_i) * 32'(b_r);
  assign p_ri = 32'(a_r) * 32'(b_i);
  assign p_br = 32'(b_r) * 32'(b_r);
  assign p_bi = 32'(b_i) * 32'(b_i);
  assign n_r = 33'(p_rr) + 33'(p_ii);
  assign n_i = 33'(p_ir) - 33'(p_ri);
  // |n| peaks at 2^31, so the 32-bit truncation of the negation is exact
  assign mag_r = n_r[32] ? 32'(-n_r) : n_r[31:0];
  assign mag_i = n_i[32] ? 32'(-n_i) : n_i[31:0];
  assign m_w = $unsigned(p_br) + $unsigned(p_bi);
  function automatic logic [31+W:0] step(input logic [31:0] rem, input logic [W-1:0] quo, input logic [31:0] d);
    logic [32:0] t;
    logic ge;
    t = {rem, quo[W-1]};
    ge = t >= {1'b0, d};
    return {ge ? 32'(t - {1'b0, d}) : t[31:0], quo[W-2:0], ge};
  endfunction
  function automatic logic [16:0] sat16(input logic [W:0] qm, input logic neg);
    return neg ? (qm > (W+1)'(32768) ? {1'b1, 16'h8000} : {1'b0, 16'(-qm)})
               : (qm > (W+1)'(32767) ? {1'b1, 16'h7fff} : {1'b0, qm[15:0]});
  endfunction
  assign {rn_r, qn_r} = step(rem_r, quo_r, m);
  assign {rn_i, qn_i} = step(rem_i, quo_i, m);
`ifdef COMPLEX_DIV_ROUND_EN
  assign qm_r = ({1'b0, qn_r} + (W+1)'(1)) >> 1;
  assign qm_i = ({1'b0, qn_i} + (W+1)'(1)) >> 1;
`else
  assign qm_r = {1'b0, qn_r};
  assign qm_i = {1'b0, qn_i};
`endif
  assign s_r = sat16(qm_r, neg_r);
  assign s_i = sat16(qm_i, neg_i);
  assign last = cnt == 6'(W - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.in_valid ? MUL : IDLE;
      MUL:  state_nx = m_w == 32'd0 ? DONE : DIV;
      DIV:  state_nx = last ? DONE : DIV;
      DONE: state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {a_r, a_i, b_r, b_i} <= '0;
      {m, rem_r, rem_i, quo_r, quo_i} <= '0;
      {neg_r, neg_i, cnt} <= '0;
      {q_r, q_i, sat, div_zero} <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) {a_r, a_i, b_r, b_i} <= {bus.num_r, bus.num_i, bus.den_r, bus.den_i};
        MUL: begin
          m <= m_w;
          {rem_r, rem_i} <= '0;
          quo_r <= W'(mag_r) << (FRAC + G);
          quo_i <= W'(mag_i) << (FRAC + G);
          {neg_r, neg_i} <= {n_r[32], n_i[32]};
          cnt <= '0;
          if (m_w == 32'd0) {q_r, q_i, sat, div_zero} <= {16'h7fff, 16'h7fff, 1'b0, 1'b1};
        end
        DIV: begin
          {rem_r, quo_r, rem_i, quo_i} <= {rn_r, qn_r, rn_i, qn_i};
          cnt <= cnt + 6'd1;
          if (last) {q_r, q_i, sat, div_zero} <= {s_r[15:0], s_i[15:0], s_r[16] | s_i[16], 1'b0};
        end
        default: ;
      endcase
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.q_r = q_r;
  assign bus.q_i = q_i;
  assign bus.sat = sat;
  assign bus.div_zero = div_zero;
endmodule

// File: tb/tb_complex_div.sv
// tb_complex_div: directed vector table plus handshake, ignore-while-busy and mid-operation reset sequences
module tb_complex_div;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  complex_div_if bus();
  complex_div #(.FRAC(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef COMPLEX_DIV_ROUND_EN
  localparam int LAT = 42;
  localparam logic [15:0] R23 = 16'd171;
`else
  localparam int LAT = 41;
  localparam logic [15:0] R23 = 16'd170;
`endif
  typedef struct {
    logic [15:0] nr, ni, dr, di, er, ei;
    logic es, ez;
    int el;
  } vec_t;
  vec_t v[12];
  int checks = 0;
  int errors = 0;
  int lat;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic start(input vec_t x);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.num_r = x.nr; bus.num_i = x.ni; bus.den_r = x.dr; bus.den_i = x.di;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
  endtask
  task automatic wait_done(input int l0, output int l);
    l = l0;
    while (!bus.out_valid && l < 200) begin
      @(posedge clk);
      #1 l++;
    end
  endtask
  task automatic check_res(input vec_t x, input int l, input string tag);
    chk({tag, "_latency"}, 32'(l), 32'(x.el));
    chk({tag, "_q_r"}, 32'(bus.q_r), 32'(x.er));
    chk({tag, "_q_i"}, 32'(bus.q_i), 32'(x.ei));
    chk({tag, "_sat"}, 32'(bus.sat), 32'(x.es));
    chk({tag, "_div_zero"}, 32'(bus.div_zero), 32'(x.ez));
  endtask
  task automatic finish_op();
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("in_ready_after_handoff", 32'(bus.in_ready), 32'd1);
    chk("out_valid_after_handoff", 32'(bus.out_valid), 32'd0);
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.num_r = '0; bus.num_i = '0; bus.den_r = '0; bus.den_i = '0;
    v[0]  = '{16'd3, 16'd4, 16'd1, 16'd2, 16'h0233, 16'hff9a, 1'b0, 1'b0, LAT};
    v[1]  = '{16'd2, 16'd0, 16'd3, 16'd0, R23, 16'h0000, 1'b0, 1'b0, LAT};
    v[2]  = '{16'd32767, 16'd0, 16'd1, 16'd0, 16'h7fff, 16'h0000, 1'b1, 1'b0, LAT};
    v[3]  = '{16'h8000, 16'd0, 16'd1, 16'd0, 16'h8000, 16'h0000, 1'b1, 1'b0, LAT};
    v[4]  = '{16'd5, 16'd5, 16'd0, 16'd0, 16'h7fff, 16'h7fff, 1'b0, 1'b1, 1};
    v[5]  = '{16'd0, 16'd100, 16'd0, 16'd1, 16'h6400, 16'h0000, 1'b0, 1'b0, LAT};
    v[6]  = '{16'hfff9, 16'd0, 16'd2, 16'd0, 16'hfc80, 16'h0000, 1'b0, 1'b0, LAT};
    v[7]  = '{16'd1, 16'd0, 16'd0, 16'd1, 16'h0000, 16'hff00, 1'b0, 1'b0, LAT};
    v[8]  = '{16'hffff, 16'd0, 16'd3, 16'd0, 16'hffab, 16'h0000, 1'b0, 1'b0, LAT};
    v[9]  = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0100, 16'h0000, 1'b0, 1'b0, LAT};
    v[10] = '{16'hff80, 16'd0, 16'd1, 16'd0, 16'h8000, 16'h0000, 1'b0, 1'b0, LAT};
    v[11] = '{16'hff7f, 16'd0, 16'd1, 16'd0, 16'h8000, 16'h0000, 1'b1, 1'b0, LAT};
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_q", {bus.q_r, bus.q_i}, 32'd0);
    chk("rst_flags", {30'd0, bus.sat, bus.div_zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      start(v[k]);
      wait_done(0, lat);
      check_res(v[k], lat, $sformatf("vec%0d", k));
      finish_op();
    end
    start(v[0]);
    wait_done(0, lat);
    check_res(v[0], lat, "hold");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("hold_q", {bus.q_r, bus.q_i}, {v[0].er, v[0].ei});
      chk("hold_ctrl", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    finish_op();
    start(v[1]);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.num_r = v[6].nr; bus.num_i = v[6].ni; bus.den_r = v[6].dr; bus.den_i = v[6].di;
    bus.in_valid = 1'b1;
    wait_done(10, lat);
    bus.in_valid = 1'b0;
    check_res(v[1], lat, "ignore");
    finish_op();
    start(v[0]);
    repeat (21) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_q", {bus.q_r, bus.q_i}, 32'd0);
    chk("midrst_flags", {30'd0, bus.sat, bus.div_zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    start(v[7]);
    wait_done(0, lat);
    check_res(v[7], lat, "after_rst");
    finish_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
